// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin arbiter for the shared 8-bit address / 32-bit data system bus.
// Registered one-hot grant, burst-hold preemption, and a grant-gated combinational bus mux.
module bus_rr_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [3:0]      M_req,
  input  logic [3:0]      M_wr,
  input  logic [4*AW-1:0] M_address,
  input  logic [4*DW-1:0] M_dout,
  output logic [3:0]      M_grant,
  output logic [DW-1:0]   M_din,
  output logic            B_valid,
  output logic            B_wr,
  output logic [AW-1:0]   B_address,
  output logic [DW-1:0]   B_wdata,
  input  logic [DW-1:0]   B_rdata,
  output logic [1:0]      owner
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [7:0] hold_cnt;
  logic [3:0] others;

  // First requesting master at or after 'start', wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign others = M_req & ~(4'b0001 << owner);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      M_grant  <= 4'b0000;
      owner    <= 2'd0;
      rr_ptr   <= 2'd0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= 8'd0;
          if (|M_req) begin
            state   <= GRANT;
            owner   <= pick(M_req, rr_ptr);
            M_grant <= 4'b0001 << pick(M_req, rr_ptr);
            rr_ptr  <= pick(M_req, rr_ptr) + 2'd1;
          end
        end
        GRANT: begin
          if (!M_req[owner] && !(|others)) begin
            state    <= IDLE;
            M_grant  <= 4'b0000;
            hold_cnt <= 8'd0;
          end else if (!M_req[owner] || hold_cnt == HOLD_LIMIT) begin
            // Release or burst limit reached: hand straight to the next waiter, no idle gap.
            owner    <= pick(others, owner + 2'd1);
            M_grant  <= 4'b0001 << pick(others, owner + 2'd1);
            rr_ptr   <= pick(others, owner + 2'd1) + 2'd1;
            hold_cnt <= 8'd0;
          end else if (|others) begin
            hold_cnt <= (hold_cnt == HOLD_LIMIT) ? hold_cnt : hold_cnt + 8'd1;
          end else begin
            hold_cnt <= 8'd0;
          end
        end
        default: begin
          state   <= IDLE;
          M_grant <= 4'b0000;
        end
      endcase
    end
  end

  assign B_valid = |M_grant;
  assign M_din   = B_rdata;

  // Mux is gated by the grant so an idle bus drives all zeros.
  always_comb begin
    B_wr      = 1'b0;
    B_address = '0;
    B_wdata   = '0;
    if (B_valid) begin
      B_wr      = M_wr[owner];
      B_address = M_address[owner*AW +: AW];
      B_wdata   = M_dout[owner*DW +: DW];
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: table-driven grant sequence plus
// hand-written mux, preemption, no-contention and async-reset sequences.
module tb_bus_rr_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MAX_HOLD = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [3:0]      M_req;
  logic [3:0]      M_wr;
  logic [4*AW-1:0] M_address;
  logic [4*DW-1:0] M_dout;
  logic [3:0]      M_grant;
  logic [DW-1:0]   M_din;
  logic            B_valid;
  logic            B_wr;
  logic [AW-1:0]   B_address;
  logic [DW-1:0]   B_wdata;
  logic [DW-1:0]   B_rdata;
  logic [1:0]      owner;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [1:0] exp_owner;
  } vec_t;

  vec_t vecs[13];

  bus_rr_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .M_req(M_req), .M_wr(M_wr),
    .M_address(M_address), .M_dout(M_dout), .M_grant(M_grant), .M_din(M_din),
    .B_valid(B_valid), .B_wr(B_wr), .B_address(B_address), .B_wdata(B_wdata),
    .B_rdata(B_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    M_req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [3:0] req);
    M_req = req;
    tick();
  endtask

  initial begin
    int n;
    int bad;
    M_wr      = 4'b0000;
    M_address = '0;
    M_dout    = '0;
    B_rdata   = '0;

    // Grant sequence starting from rr_ptr=0 after reset.
    vecs[0]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[1]  = '{4'b1110, 4'b0010, 2'd1};
    vecs[2]  = '{4'b1100, 4'b0100, 2'd2};
    vecs[3]  = '{4'b1000, 4'b1000, 2'd3};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd0};
    vecs[5]  = '{4'b0110, 4'b0010, 2'd1};
    vecs[6]  = '{4'b0110, 4'b0010, 2'd1};
    vecs[7]  = '{4'b0100, 4'b0100, 2'd2};
    vecs[8]  = '{4'b0101, 4'b0100, 2'd2};
    vecs[9]  = '{4'b0001, 4'b0001, 2'd0};
    vecs[10] = '{4'b1001, 4'b0001, 2'd0};
    vecs[11] = '{4'b1000, 4'b1000, 2'd3};
    vecs[12] = '{4'b0000, 4'b0000, 2'd0};

    apply_reset();
    check_output("reset_grant", 32'(M_grant), 32'h0);
    check_output("reset_valid", 32'(B_valid), 32'h0);
    check_output("reset_owner", 32'(owner), 32'h0);

    apply_stimulus(4'b0001);
    check_output("first_grant", 32'(M_grant), 32'h1);
    check_output("first_valid", 32'(B_valid), 32'h1);
    check_output("first_owner", 32'(owner), 32'h0);
    apply_stimulus(4'b0000);
    check_output("release_grant", 32'(M_grant), 32'h0);

    apply_reset();
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].req);
      check_output($sformatf("vec%0d_grant", i), 32'(M_grant), 32'(vecs[i].exp_grant));
      check_output($sformatf("vec%0d_valid", i), 32'(B_valid), 32'(|vecs[i].exp_grant));
      if (vecs[i].exp_grant != 4'b0000)
        check_output($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].exp_owner));
    end

    // A request pulse that never spans a clock edge must be ignored.
    tick();
    #2 M_req = 4'b0100;
    #2 M_req = 4'b0000;
    tick();
    check_output("glitch_ignored", 32'(M_grant), 32'h0);

    // Bus mux for master 1.
    apply_reset();
    M_wr      = 4'b0010;
    M_address = {8'h0F, 8'h0A, 8'h04, 8'h01};
    M_dout    = {32'h70, 32'h50, 32'h30, 32'h10};
    #1;
    check_output("idle_addr", 32'(B_address), 32'h0);
    check_output("idle_wr", 32'(B_wr), 32'h0);
    check_output("idle_wdata", B_wdata, 32'h0);
    apply_stimulus(4'b0010);
    check_output("mux_grant", 32'(M_grant), 32'h2);
    check_output("mux_addr", 32'(B_address), 32'h04);
    check_output("mux_wr", 32'(B_wr), 32'h1);
    check_output("mux_wdata", B_wdata, 32'h30);
    B_rdata = 32'hA5A5_0001;
    #1 check_output("mux_rdata", M_din, 32'hA5A5_0001);
    apply_stimulus(4'b0000);

    // Burst preemption: master 0 waits behind a continuous master-1 request.
    apply_reset();
    apply_stimulus(4'b0010);
    check_output("burst_start", 32'(M_grant), 32'h2);
    apply_stimulus(4'b0010);
    apply_stimulus(4'b0010);
    M_req = 4'b0011;
    n = 0;
    bad = 0;
    while (M_grant != 4'b0001 && n < 40) begin
      tick();
      n++;
      if (M_grant != 4'b0001 && M_grant != 4'b0010) bad++;
    end
    check_output("preempt_cycles", 32'(n), 32'd16);
    check_output("preempt_glitches", 32'(bad), 32'd0);
    check_output("preempt_grant", 32'(M_grant), 32'h1);
    apply_stimulus(4'b0010);
    check_output("preempt_return", 32'(M_grant), 32'h2);
    apply_stimulus(4'b0000);

    // Lone master holds indefinitely without the hold counter moving.
    apply_stimulus(4'b0010);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(4'b0010);
      if (M_grant != 4'b0010 || dut.hold_cnt != 8'd0) bad++;
    end
    check_output("solo_hold_errs", 32'(bad), 32'd0);

    // Async reset in the middle of a write burst from master 1.
    tick();
    #3 reset_n = 1'b0;
    #1;
    check_output("areset_grant", 32'(M_grant), 32'h0);
    check_output("areset_wr", 32'(B_wr), 32'h0);
    check_output("areset_addr", 32'(B_address), 32'h0);
    M_req = 4'b0110;
    #2 reset_n = 1'b1;
    tick();
    check_output("after_reset_grant", 32'(M_grant), 32'h2);
    check_output("after_reset_owner", 32'(owner), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one 8-bit-address / 32-bit-data system bus among four masters: CPU/testbench, DMAC, and two expansion ports.
- Each master raises M_req and receives a one-hot registered grant.
- The block muxes the granted master's address, write strobe and write data onto the shared bus, and broadcasts read data back to all masters.
- Round-robin fairness, plus a burst-hold limit so a long DMA transfer cannot starve the CPU.

Parameters:
- AW, 8, address width.
- DW, 32, data width.
- MAX_HOLD, 16, maximum consecutive grant cycles while another master waits. Legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- M_req  input  4  per-master bus request. Bit i belongs to master i.
- M_wr  input  4  per-master write(1)/read(0).
- M_address  input  4*AW  packed addresses; master i occupies [i*AW +: AW].
- M_dout  input  4*DW  packed write data; master i occupies [i*DW +: DW].
- M_grant  output  4  one-hot grant, registered.
- M_din  output  DW  read data broadcast to all masters; equals B_rdata.
- B_valid  output  1  a master currently owns the bus (|M_grant).
- B_wr  output  1  muxed write strobe.
- B_address  output  AW  muxed address.
- B_wdata  output  DW  muxed write data.
- B_rdata  input  DW  read data from the slave decoder.
- owner  output  2  index of the granted master. Meaningful only when B_valid=1.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, M_grant=4'b0000, owner=0, rr_ptr=0, hold_cnt=0.
  - All B_* outputs read 0 because the mux is gated by the grant.
- State IDLE:
  - Sample M_req on each edge. If nonzero, move to GRANT.
  - Grant the first requesting master searching rr_ptr, rr_ptr+1, ... (mod 4).
  - Latency: req seen at edge k, grant visible after edge k (one cycle).
- State GRANT, owner o, evaluated at each edge:
  - M_req[o]=0 and other requests pending: hand over directly to the next requester searching from o+1. No idle cycle. hold_cnt=0.
  - M_req[o]=0 and no other requests: go to IDLE, M_grant=0.
  - M_req[o]=1, another request pending, hold_cnt==MAX_HOLD-1: preempt. Grant the next requester from o+1; hold_cnt=0. The preempted master keeps its request and waits its turn.
  - M_req[o]=1 otherwise: keep the grant.
    - hold_cnt increments only while another request is pending, else clears to 0.
    - Saturates at MAX_HOLD-1.
- rr_ptr update: on every new grant to master g, rr_ptr=g+1 mod 4. A master that just released or was preempted therefore has lowest priority.
- Grant is always one-hot or zero, never more than one bit.
- Mux is combinational from the registered M_grant:
  - B_wr = M_wr[owner], B_address = owner slice, B_wdata = owner slice.
  - All are 0 when no grant.
- M_din = B_rdata continuously.
- Simultaneous requests from IDLE are resolved purely by rr_ptr.
- A request asserted and dropped before being sampled is ignored.
- Req of a non-owner toggling during GRANT does not affect the current owner except through preemption.
- Reset mid-transfer: grant drops immediately (async), no bus cycle completes, rr_ptr returns to 0.

Test Plan:
- Reset priority: reset, then M_req=4'b0001 → M_grant=4'b0001 one cycle later, B_valid=1, owner=0. M_req=0 → M_grant=0 next cycle.
- Round-robin: M_req=4'b1111, each owner drops its request one cycle after its grant → grant order 0001, 0010, 0100, 1000 with no gaps.
- Bus mux: grant master 1 with M_address[15:8]=8'h04, M_wr[1]=1, M_dout[63:32]=32'h0000_0030 → B_address=8'h04, B_wr=1, B_wdata=32'h0000_0030. Drive B_rdata=32'hA5A5_0001 → M_din=32'hA5A5_0001.
- Burst preemption: master 1 holds its request continuously, master 0 requests 3 cycles after master 1's grant → with MAX_HOLD=16, grant moves to 0001 exactly 16 cycles after master 0's request is first sampled, then returns to 0010 when master 0 drops its request.
- No-contention hold: master 1 alone holds its request for 40 cycles → M_grant stays 0010 throughout, hold_cnt stays 0.
- Async reset: assert reset_n=0 mid-burst between clock edges → M_grant=0, B_wr=0 and B_address=0 immediately. After release with M_req=4'b0110 → grant 0010.
